game_controller: RTL

Central game sequencer for Chip Invaders, running in the 25 MHz pixel clock domain next to `hvsync_generator`. It watches the per-pixel sprite outputs (laser, alien formation, cannon, alien bomb) to detect collisions within each frame. At each frame boundary it commits the results: it pulses `hit_alien` into `cannon_laser`, tells `alien_formation` which alien to kill, and updates the score and lives that drive `hud`. It also owns the game state machine (idle, play, death, wave clear, game over) and gates player movement.

---
 rtl/invaders_pkg.sv | 18 +
 rtl/game_controller_if.sv | 39 +++
 rtl/collision_detector.sv | 52 +++++
 rtl/game_controller.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/invaders_pkg.sv
// Shared Chip Invaders types and constants: game state encoding (also used by hud),
// score width/saturation and frame-timer width.
package invaders_pkg;

    localparam int SCORE_W = 8;
    localparam int TIMER_W = 8;
    localparam logic [SCORE_W-1:0] SCORE_MAX   = 8'd255;
    localparam logic [SCORE_W-1:0] BONUS_SCORE = 8'd100;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        PLAY       = 3'd1,
        DYING      = 3'd2,
        WAVE_CLEAR = 3'd3,
        GAME_OVER  = 3'd4
    } game_state_t;

endpackage

// File: rtl/game_controller_if.sv
// Bundle between the video/sprite side (master) and the game controller (slave).
interface game_controller_if;
    import invaders_pkg::*;

    logic                frame_tick;
    logic                display_on;
    logic [9:0]          hpos;
    logic [9:0]          vpos;
    logic                laser_gfx;
    logic                alien_pixel;
    logic                cannon_gfx;
    logic                bomb_gfx;
    logic                wave_cleared;
    logic                aliens_landed;
    logic                start;
    logic                hit_alien;
    logic [9:0]          kill_x;
    logic [9:0]          kill_y;
    logic [SCORE_W-1:0]  score;
    logic [1:0]          lives;
    logic                play_enable;
    logic                formation_reset;
    game_state_t         game_state;

    modport master (
        output frame_tick, display_on, hpos, vpos, laser_gfx, alien_pixel,
               cannon_gfx, bomb_gfx, wave_cleared, aliens_landed, start,
        input  hit_alien, kill_x, kill_y, score, lives, play_enable,
               formation_reset, game_state
    );

    modport slave (
        input  frame_tick, display_on, hpos, vpos, laser_gfx, alien_pixel,
               cannon_gfx, bomb_gfx, wave_cleared, aliens_landed, start,
        output hit_alien, kill_x, kill_y, score, lives, play_enable,
               formation_reset, game_state
    );

endinterface

// File: rtl/collision_detector.sv
// Per-frame collision scan: pending flags for alien kill / player death and the
// coordinate of the first laser-alien overlap, all cleared by frame_tick.
module collision_detector
    import invaders_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       scan_en,
    input  logic       frame_tick,
    input  logic       display_on,
    input  logic [9:0] hpos,
    input  logic [9:0] vpos,
    input  logic       laser_gfx,
    input  logic       alien_pixel,
    input  logic       cannon_gfx,
    input  logic       bomb_gfx,
    input  logic       aliens_landed,
    output logic       alien_pend,
    output logic       player_pend,
    output logic [9:0] hit_x,
    output logic [9:0] hit_y
);

    logic alien_hit_p0;
    logic player_hit_p0;

    assign alien_hit_p0  = scan_en & display_on & laser_gfx & alien_pixel;
    assign player_hit_p0 = scan_en & display_on & ((cannon_gfx & bomb_gfx) | aliens_landed);

    // Stage p1: pending flags; only the first overlap of a frame updates the coordinate
    always_ff @(posedge clk) begin
        if (reset) begin
            alien_pend  <= 1'b0;
            player_pend <= 1'b0;
            hit_x       <= '0;
            hit_y       <= '0;
        end else if (frame_tick) begin
            alien_pend  <= 1'b0;
            player_pend <= 1'b0;
        end else begin
            if (alien_hit_p0 && !alien_pend) begin
                alien_pend <= 1'b1;
                hit_x      <= hpos;
                hit_y      <= vpos;
            end
            if (player_hit_p0) begin
                player_pend <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/game_controller.sv
// Chip Invaders game sequencer: FSM, frame timer, score and lives.
// Optional feature macro: GAME_CTRL_BONUS_LIFE_EN (one extra life at score 100).
module game_controller
    import invaders_pkg::*;
#(
    parameter int POINTS_PER_ALIEN = 10,
    parameter int START_LIVES      = 3,
    parameter int DEATH_FRAMES     = 90,
    parameter int WAVE_FRAMES      = 60,
    parameter int OVER_FRAMES      = 120
)(
    input  logic              clk,
    input  logic              reset,
    game_controller_if.slave  bus
);

    if (DEATH_FRAMES < 0 || DEATH_FRAMES > 255 || WAVE_FRAMES < 0 || WAVE_FRAMES > 255 ||
        OVER_FRAMES < 0 || OVER_FRAMES > 255) begin : g_bad_timer
        $error("game_controller: frame counts must fit the 8-bit timer");
    end
    if (START_LIVES < 1 || START_LIVES > 3) begin : g_bad_lives
        $error("game_controller: START_LIVES must be 1..3");
    end
    if (POINTS_PER_ALIEN < 0 || POINTS_PER_ALIEN > 255) begin : g_bad_points
        $error("game_controller: POINTS_PER_ALIEN must fit the score width");
    end

    localparam logic [TIMER_W-1:0] DEATH_T = TIMER_W'(DEATH_FRAMES);
    localparam logic [TIMER_W-1:0] WAVE_T  = TIMER_W'(WAVE_FRAMES);
    localparam logic [TIMER_W-1:0] OVER_T  = TIMER_W'(OVER_FRAMES);
    localparam logic [SCORE_W-1:0] POINTS  = SCORE_W'(POINTS_PER_ALIEN);
    localparam logic [1:0]         LIVES0  = 2'(START_LIVES);

    function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                   input logic [SCORE_W-1:0] b);
        logic [SCORE_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[SCORE_W] ? SCORE_MAX : sum[SCORE_W-1:0];
    endfunction

    function automatic logic [1:0] lives_dec(input logic [1:0] l);
        return (l == 2'd0) ? 2'd0 : l - 2'd1;
    endfunction

    game_state_t         state, state_nxt;
    logic [TIMER_W-1:0]  timer, timer_nxt;
    logic [SCORE_W-1:0]  score, score_nxt;
    logic [1:0]          lives, lives_nxt;
    logic                hit_p1, hit_nxt;
    logic                freset_p1, freset_nxt;
    logic [9:0]          kill_x, kill_x_nxt, kill_y, kill_y_nxt;
    logic                start_q, start_edge, game_start, timer_done;
    logic                alien_pend, player_pend;
    logic [9:0]          hit_x, hit_y;
`ifdef GAME_CTRL_BONUS_LIFE_EN
    logic                bonus_given, bonus_nxt;
`endif

    collision_detector u_collide (
        .clk          (clk),
        .reset        (reset),
        .scan_en      (state == PLAY),
        .frame_tick   (bus.frame_tick),
        .display_on   (bus.display_on),
        .hpos         (bus.hpos),
        .vpos         (bus.vpos),
        .laser_gfx    (bus.laser_gfx),
        .alien_pixel  (bus.alien_pixel),
        .cannon_gfx   (bus.cannon_gfx),
        .bomb_gfx     (bus.bomb_gfx),
        .aliens_landed(bus.aliens_landed),
        .alien_pend   (alien_pend),
        .player_pend  (player_pend),
        .hit_x        (hit_x),
        .hit_y        (hit_y)
    );

    // start_q resets high so a button held through reset produces no edge
    always_ff @(posedge clk) begin
        if (reset) start_q <= 1'b1;
        else       start_q <= bus.start;
    end

    assign start_edge = bus.start & ~start_q;
    assign game_start = start_edge &&
                        (state == IDLE || (state == GAME_OVER && timer == '0));
    assign timer_done = bus.frame_tick && (timer <= TIMER_W'(1));

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (game_start) begin
            state_nxt = PLAY;
        end else begin
            case (state)
                PLAY: if (bus.frame_tick) begin
                    if (player_pend)           state_nxt = DYING;
                    else if (bus.wave_cleared) state_nxt = WAVE_CLEAR;
                end
                DYING:      if (timer_done) state_nxt = (lives == 2'd0) ? GAME_OVER : PLAY;
                WAVE_CLEAR: if (timer_done) state_nxt = PLAY;
                default:    state_nxt = state;
            endcase
        end
    end

    always_comb begin
        timer_nxt  = timer;
        score_nxt  = score;
        lives_nxt  = lives;
        hit_nxt    = 1'b0;
        freset_nxt = 1'b0;
        kill_x_nxt = kill_x;
        kill_y_nxt = kill_y;
`ifdef GAME_CTRL_BONUS_LIFE_EN
        bonus_nxt  = bonus_given;
`endif
        if (game_start) begin
            lives_nxt  = LIVES0;
            score_nxt  = '0;
            timer_nxt  = '0;
            freset_nxt = 1'b1;
`ifdef GAME_CTRL_BONUS_LIFE_EN
            bonus_nxt  = 1'b0;
`endif
        end else begin
            case (state)
                PLAY: if (bus.frame_tick) begin
                    if (alien_pend) begin
                        hit_nxt    = 1'b1;
                        score_nxt  = sat_add(score, POINTS);
                        kill_x_nxt = hit_x;
                        kill_y_nxt = hit_y;
                    end
                    if (player_pend) begin
                        lives_nxt = lives_dec(lives);
                        timer_nxt = DEATH_T;
                    end else if (bus.wave_cleared) begin
                        timer_nxt = WAVE_T;
                    end
`ifdef GAME_CTRL_BONUS_LIFE_EN
                    if (!bonus_given && score < BONUS_SCORE && score_nxt >= BONUS_SCORE) begin
                        bonus_nxt = 1'b1;
                        if (lives_nxt != 2'd3) lives_nxt = lives_nxt + 2'd1;
                    end
`endif
                end
                DYING, WAVE_CLEAR: if (bus.frame_tick) begin
                    if (timer_done) begin
                        timer_nxt = '0;
                        if (state == DYING && lives == 2'd0) timer_nxt = OVER_T;
                        else                                 freset_nxt = 1'b1;
                    end else begin
                        timer_nxt = timer - TIMER_W'(1);
                    end
                end
                GAME_OVER: if (bus.frame_tick && timer != '0) timer_nxt = timer - TIMER_W'(1);
                default: ;
            endcase
        end
    end

    // Stage p1: registered outputs, one cycle after frame_tick / start edge
    always_ff @(posedge clk) begin
        if (reset) begin
            timer     <= '0;
            score     <= '0;
            lives     <= '0;
            hit_p1    <= 1'b0;
            freset_p1 <= 1'b0;
            kill_x    <= '0;
            kill_y    <= '0;
`ifdef GAME_CTRL_BONUS_LIFE_EN
            bonus_given <= 1'b0;
`endif
        end else begin
            timer     <= timer_nxt;
            score     <= score_nxt;
            lives     <= lives_nxt;
            hit_p1    <= hit_nxt;
            freset_p1 <= freset_nxt;
            kill_x    <= kill_x_nxt;
            kill_y    <= kill_y_nxt;
`ifdef GAME_CTRL_BONUS_LIFE_EN
            bonus_given <= bonus_nxt;
`endif
        end
    end

    assign bus.hit_alien       = hit_p1;
    assign bus.kill_x          = kill_x;
    assign bus.kill_y          = kill_y;
    assign bus.score           = score;
    assign bus.lives           = lives;
    assign bus.formation_reset = freset_p1;
    assign bus.play_enable     = (state == PLAY);
    assign bus.game_state      = state;

endmodule
